pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage core. Each cycle it produces the enables for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers, plus the bubble-insert and flush controls. It resolves load-use hazards, memory stalls, multi-cycle divides and exception flushes with a fixed priority. It sits beside the hazard/forwarding logic and drives the `i_ena` inputs of every pipeline register.

## Interface
- `DIV_CYCLES`, 32: cycles the pipeline freezes per divide; must be >= 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_ID_rs_addr` in 5: rs index of the instruction in ID.
- `i_ID_rt_addr` in 5: rt index of the instruction in ID.
- `i_ID_uses_rs` in 1: the ID instruction reads rs.
- `i_ID_uses_rt` in 1: the ID instruction reads rt.
- `i_EXE_GPR_waddr` in 5: GPR write index of the instruction in EXE.
- `i_EXE_GPR_we` in 1: the EXE instruction writes a GPR.
- `i_EXE_get_result_in_MEM` in 1: the EXE instruction's result is available only in MEM (load).
- `i_EXE_is_div` in 1: the EXE instruction is a divide.
- `i_mem_stall` in 1: data or instruction memory is not ready; freeze everything.
- `i_exception` in 1: an exception or eret is committing this cycle.
- `o_PC_ena` out 1: PC register enable.
- `o_IF_ID_ena` out 1: IF/ID register enable.
- `o_ID_EXE_ena` out 1: ID/EXE register enable.
- `o_EXE_MEM_ena` out 1: EXE/MEM register enable.
- `o_ID_EXE_bubble` out 1: ID forces all write-enable, branch and except-cause controls to 0 on the ID/EXE inputs.
- `o_flush` out 1: IF/ID and ID/EXE load a NOP this cycle.
- `o_div_start` out 1: one-cycle pulse that starts the divider.
- `o_div_abort` out 1: one-cycle pulse that cancels an in-flight divide.
- `o_state` out 2: current FSM state, for debug.

## Operation
- States: `RUN`=0, `DIV_WAIT`=1, `FLUSH`=2.
- Internal down-counter `cnt`, width `$clog2(DIV_CYCLES)`.
- Load-use hazard: `hz` = `i_EXE_get_result_in_MEM` & `i_EXE_GPR_we` & (`i_EXE_GPR_waddr` != 0) & ((`i_ID_uses_rs` & rs match) | (`i_ID_uses_rt` & rt match)).
- Outputs are combinational from state, `cnt` and inputs. Rules are evaluated in priority order; the first match wins.
  1. `i_exception`:
     - All four enables 1, `o_flush`=1, `o_ID_EXE_bubble`=1.
     - `o_div_abort`=1 if state is `DIV_WAIT`.
     - Next state `FLUSH`, `cnt`<=0.
  2. `i_mem_stall`:
     - All enables 0, bubble 0.
     - State holds. In `DIV_WAIT`, `cnt` still decrements while nonzero.
  3. `RUN` & `i_EXE_is_div`:
     - All enables 0, `o_div_start`=1.
     - `cnt`<=`DIV_CYCLES`-1, next `DIV_WAIT`.
  4. `DIV_WAIT` & `cnt`!=0: all enables 0, `cnt`<=`cnt`-1.
  5. `DIV_WAIT` & `cnt`==0: apply rules 6/7, next `RUN`. The divide leaves EXE in this cycle, so it does not retrigger.
  6. `hz` (in `RUN` or `FLUSH`):
     - `o_PC_ena`=0, `o_IF_ID_ena`=0.
     - `o_ID_EXE_ena`=1, `o_ID_EXE_bubble`=1, `o_EXE_MEM_ena`=1.
  7. Otherwise: all enables 1, bubble 0.
- `FLUSH` without exception or memory stall: rules 6/7 apply with `o_ID_EXE_bubble` forced to 1, then next `RUN`. This squashes the fetch that was in flight when the exception hit.
- `o_div_start` and `o_div_abort` are never 1 in the same cycle.

## Timing
- While `resetn`=0: state=`RUN`, `cnt`=0, and every output is 0.
- First cycle after reset release: normal `RUN` outputs.
- Divide freezes the pipeline for exactly `DIV_CYCLES` cycles when there is no memory stall: one entry cycle plus `DIV_CYCLES`-1 in `DIV_WAIT`. EXE/MEM captures the divide on the following cycle.
- Memory stall during `DIV_WAIT` with `cnt`==0: the FSM stays in `DIV_WAIT` with `cnt`=0 until the stall clears.
- Load-use hazard costs exactly 1 bubble. On the next cycle the load is in MEM and `hz` is false.
- Exception latency: `o_flush` is asserted in the same cycle as `i_exception`. `FLUSH` lasts 1 cycle, or longer if `i_mem_stall` holds it.
- `resetn` asserted mid-divide: `cnt` clears immediately and no abort pulse is issued.

## Configuration
- `PIPE_CTRL_DIV_STALL_EN` defined: divide sequencing behaves as described above.
- `PIPE_CTRL_DIV_STALL_EN` undefined:
  - The `DIV_WAIT` state and `cnt` are not built.
  - `i_EXE_is_div` is ignored, and `o_div_start`/`o_div_abort` are tied to 0; the divider is single-cycle.
  - `o_state` never reads 1.

## Test plan
- Reset, release, no hazards: every enable is 1 each cycle, bubble=0, `o_state`=0.
- Load to $5 in EXE with `i_ID_rs_addr`=5 and `uses_rs`=1: one cycle with PC/IF_ID=0 and bubble=1. Repeat with waddr=0: no stall.
- Divide with `DIV_CYCLES`=4: `o_div_start` pulses once and enables are 0 for exactly 4 cycles. Add a 2-cycle `i_mem_stall` overlapping `cnt`==0: total freeze is 5 cycles.
- `i_exception` in the 2nd `DIV_WAIT` cycle: `o_div_abort`=1 and `o_flush`=1 that cycle, then `FLUSH` for 1 cycle with bubble=1, then `RUN`.
- `i_exception` and a load-use hazard in the same cycle: flush wins, no PC freeze. Exception plus `i_mem_stall`: flush wins.
- `resetn` pulled low mid-divide: all outputs are 0 at once, and the first cycle after release is `RUN` with `cnt`=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: PC and pipeline-register enables, bubble, flush and divider control.
// Divide sequencing (DIV_WAIT state and down-counter) is built only when PIPE_CTRL_DIV_STALL_EN is defined.
module pipeline_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] i_ID_rs_addr,
    input  logic [4:0] i_ID_rt_addr,
    input  logic       i_ID_uses_rs,
    input  logic       i_ID_uses_rt,
    input  logic [4:0] i_EXE_GPR_waddr,
    input  logic       i_EXE_GPR_we,
    input  logic       i_EXE_get_result_in_MEM,
    input  logic       i_EXE_is_div,
    input  logic       i_mem_stall,
    input  logic       i_exception,
    output logic       o_PC_ena,
    output logic       o_IF_ID_ena,
    output logic       o_ID_EXE_ena,
    output logic       o_EXE_MEM_ena,
    output logic       o_ID_EXE_bubble,
    output logic       o_flush,
    output logic       o_div_start,
    output logic       o_div_abort,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDivWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   hz;
    logic   pc_ena, if_id_ena, id_exe_ena, exe_mem_ena;
    logic   bubble, flush, div_start, div_abort;

    assign hz = i_EXE_get_result_in_MEM & i_EXE_GPR_we & (i_EXE_GPR_waddr != 5'd0) &
                ((i_ID_uses_rs & (i_ID_rs_addr == i_EXE_GPR_waddr)) |
                 (i_ID_uses_rt & (i_ID_rt_addr == i_EXE_GPR_waddr)));

`ifdef PIPE_CTRL_DIV_STALL_EN
    localparam int unsigned CntW = $clog2(DIV_CYCLES);
    localparam logic [CntW-1:0] CntInit = CntW'(DIV_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_div;
    assign unused_div = i_EXE_is_div ^ DIV_CYCLES[0];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_ena      = 1'b1;
        if_id_ena   = 1'b1;
        id_exe_ena  = 1'b1;
        exe_mem_ena = 1'b1;
        bubble      = 1'b0;
        flush       = 1'b0;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        state_d     = state_q;
`ifdef PIPE_CTRL_DIV_STALL_EN
        cnt_d       = cnt_q;
`endif
        if (i_exception) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = StFlush;
`ifdef PIPE_CTRL_DIV_STALL_EN
            div_abort = (state_q == StDivWait);
            cnt_d     = '0;
`endif
        end else if (i_mem_stall) begin
            pc_ena      = 1'b0;
            if_id_ena   = 1'b0;
            id_exe_ena  = 1'b0;
            exe_mem_ena = 1'b0;
`ifdef PIPE_CTRL_DIV_STALL_EN
            // The divider keeps running even while memory freezes the pipeline.
            if (state_q == StDivWait && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
`endif
        end
`ifdef PIPE_CTRL_DIV_STALL_EN
        else if (state_q == StRun && i_EXE_is_div) begin
            pc_ena      = 1'b0;
            if_id_ena   = 1'b0;
            id_exe_ena  = 1'b0;
            exe_mem_ena = 1'b0;
            div_start   = 1'b1;
            cnt_d       = CntInit;
            state_d     = StDivWait;
        end else if (state_q == StDivWait && cnt_q != '0) begin
            pc_ena      = 1'b0;
            if_id_ena   = 1'b0;
            id_exe_ena  = 1'b0;
            exe_mem_ena = 1'b0;
            cnt_d       = cnt_q - 1'b1;
        end
`endif
        else begin
            if (hz) begin
                pc_ena    = 1'b0;
                if_id_ena = 1'b0;
                bubble    = 1'b1;
            end
            // Squash the fetch that was in flight when the exception hit.
            if (state_q == StFlush) begin
                bubble = 1'b1;
            end
            state_d = StRun;
        end
    end

    assign o_PC_ena        = resetn & pc_ena;
    assign o_IF_ID_ena     = resetn & if_id_ena;
    assign o_ID_EXE_ena    = resetn & id_exe_ena;
    assign o_EXE_MEM_ena   = resetn & exe_mem_ena;
    assign o_ID_EXE_bubble = resetn & bubble;
    assign o_flush         = resetn & flush;
    assign o_div_start     = resetn & div_start;
    assign o_div_abort     = resetn & div_abort;
    assign o_state         = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_pipeline_stall_ctrl;

    localparam int unsigned DivCycles = 4;

    // Expected output word: {pc, if_id, id_exe, exe_mem, bubble, flush, start, abort, state[1:0]}
    localparam logic [9:0] Nrm  = 10'b1111_0000_00;
    localparam logic [9:0] Hzd  = 10'b0011_1000_00;
    localparam logic [9:0] Stl  = 10'b0000_0000_00;
    localparam logic [9:0] Exc  = 10'b1111_1100_00;
    localparam logic [9:0] ExcF = 10'b1111_1100_10;
    localparam logic [9:0] Fl   = 10'b1111_1000_10;
    localparam logic [9:0] FlHz = 10'b0011_1000_10;
    localparam logic [9:0] FlSt = 10'b0000_0000_10;
    localparam logic [9:0] Zero = 10'b0000_0000_00;
    localparam logic [9:0] DvS  = 10'b0000_0010_00;
    localparam logic [9:0] DvW  = 10'b0000_0000_01;
    localparam logic [9:0] DvR  = 10'b1111_0000_01;
    localparam logic [9:0] DvA  = 10'b1111_1101_01;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] rs, rt, waddr;
    logic       urs, urt, we, ld, dv, ms, ex;
    logic       pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, bubble, flush, div_start, div_abort;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] waddr;
        logic       we, ld, dv, ms, ex;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.DIV_CYCLES(DivCycles)) dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .i_ID_rs_addr            (rs),
        .i_ID_rt_addr            (rt),
        .i_ID_uses_rs            (urs),
        .i_ID_uses_rt            (urt),
        .i_EXE_GPR_waddr         (waddr),
        .i_EXE_GPR_we            (we),
        .i_EXE_get_result_in_MEM (ld),
        .i_EXE_is_div            (dv),
        .i_mem_stall             (ms),
        .i_exception             (ex),
        .o_PC_ena                (pc_ena),
        .o_IF_ID_ena             (if_id_ena),
        .o_ID_EXE_ena            (id_exe_ena),
        .o_EXE_MEM_ena           (exe_mem_ena),
        .o_ID_EXE_bubble         (bubble),
        .o_flush                 (flush),
        .o_div_start             (div_start),
        .o_div_abort             (div_abort),
        .o_state                 (state)
    );

    function automatic vec_t mk(input string n, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                input logic a_urs, input logic a_urt, input logic [4:0] a_wa,
                                input logic a_we, input logic a_ld, input logic a_dv,
                                input logic a_ms, input logic a_ex, input logic [9:0] e);
        vec_t t;
        t.name = n; t.rs = a_rs; t.rt = a_rt; t.urs = a_urs; t.urt = a_urt; t.waddr = a_wa;
        t.we = a_we; t.ld = a_ld; t.dv = a_dv; t.ms = a_ms; t.ex = a_ex; t.exp = e;
        return t;
    endfunction

    function automatic vec_t ctl(input string n, input logic a_dv, input logic a_ms,
                                 input logic a_ex, input logic [9:0] e);
        return mk(n, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, a_dv, a_ms, a_ex, e);
    endfunction

    task automatic drive(input vec_t t);
        rs = t.rs; rt = t.rt; urs = t.urs; urt = t.urt; waddr = t.waddr;
        we = t.we; ld = t.ld; dv = t.dv; ms = t.ms; ex = t.ex;
    endtask

    task automatic compare();
        logic [9:0] got;
        logic [9:0] e;
        string      n;
        got = {pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, bubble, flush,
               div_start, div_abort, state};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, got, e);
        end
        if (div_start && div_abort) begin
            errors++;
            $display("FAIL %s: div_start and div_abort both high", n);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        drive(t);
        exp_q.push_back(t.exp);
        name_q.push_back(t.name);
        #2;
        compare();
    endtask

    task automatic check_now(input string n, input logic [9:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
        #1;
        compare();
    endtask

    initial begin
        resetn = 1'b0;
        drive(ctl("init", 1'b0, 1'b0, 1'b0, Zero));
        @(negedge clk);
        check_now("reset_idle", Zero);
        // Active inputs must not leak through while reset is held.
        drive(mk("rst_busy", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Zero));
        check_now("reset_busy", Zero);
        @(negedge clk);
        drive(ctl("idle", 1'b0, 1'b0, 1'b0, Zero));
        resetn = 1'b1;

        tbl.push_back(ctl("run_idle", 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("lu_rs5", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Hzd));
        tbl.push_back(mk("lu_after", 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("lu_r0", 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("lu_rt7", 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Hzd));
        tbl.push_back(mk("lu_unused", 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("lu_no_we", 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("alu_fwd", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(mk("mstall_hz", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, Stl));
        tbl.push_back(mk("exc_hz", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Exc));
        tbl.push_back(ctl("flush_1", 1'b0, 1'b0, 1'b0, Fl));
        tbl.push_back(ctl("run_post", 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(ctl("exc_mstall", 1'b0, 1'b1, 1'b1, Exc));
        tbl.push_back(ctl("flush_ms1", 1'b0, 1'b1, 1'b0, FlSt));
        tbl.push_back(ctl("flush_ms2", 1'b0, 1'b1, 1'b0, FlSt));
        tbl.push_back(mk("flush_hz", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FlHz));
        tbl.push_back(ctl("run_a", 1'b0, 1'b0, 1'b0, Nrm));
        tbl.push_back(ctl("exc_a", 1'b0, 1'b0, 1'b1, Exc));
        tbl.push_back(ctl("exc_in_fl", 1'b0, 1'b0, 1'b1, ExcF));
        tbl.push_back(ctl("flush_b", 1'b0, 1'b0, 1'b0, Fl));
`ifndef PIPE_CTRL_DIV_STALL_EN
        tbl.push_back(ctl("div_ignored", 1'b1, 1'b0, 1'b0, Nrm));
        tbl.push_back(ctl("div_ignored2", 1'b1, 1'b0, 1'b0, Nrm));
`endif
        tbl.push_back(ctl("run_end", 1'b0, 1'b0, 1'b0, Nrm));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

`ifdef PIPE_CTRL_DIV_STALL_EN
        // Plain divide: DivCycles frozen cycles, then release.
        apply(ctl("div_start", 1'b1, 1'b0, 1'b0, DvS));
        for (int i = 1; i < DivCycles; i++) apply(ctl("div_wait", 1'b1, 1'b0, 1'b0, DvW));
        apply(ctl("div_release", 1'b1, 1'b0, 1'b0, DvR));
        apply(ctl("div_after", 1'b0, 1'b0, 1'b0, Nrm));

        // Memory stall covering cnt==1 and cnt==0 adds one frozen cycle.
        apply(ctl("dms_start", 1'b1, 1'b0, 1'b0, DvS));
        apply(ctl("dms_w3", 1'b1, 1'b0, 1'b0, DvW));
        apply(ctl("dms_w2", 1'b1, 1'b0, 1'b0, DvW));
        apply(ctl("dms_w1_ms", 1'b1, 1'b1, 1'b0, DvW));
        apply(ctl("dms_w0_ms", 1'b1, 1'b1, 1'b0, DvW));
        apply(ctl("dms_release", 1'b1, 1'b0, 1'b0, DvR));
        apply(ctl("dms_after", 1'b0, 1'b0, 1'b0, Nrm));

        // Exception in the second DIV_WAIT cycle aborts the divide.
        apply(ctl("dex_start", 1'b1, 1'b0, 1'b0, DvS));
        apply(ctl("dex_w1", 1'b1, 1'b0, 1'b0, DvW));
        apply(ctl("dex_abort", 1'b1, 1'b0, 1'b1, DvA));
        apply(ctl("dex_flush", 1'b0, 1'b0, 1'b0, Fl));
        apply(ctl("dex_run", 1'b0, 1'b0, 1'b0, Nrm));

        // Reset mid-divide, then a fresh divide must take the full count.
        apply(ctl("drs_start", 1'b1, 1'b0, 1'b0, DvS));
        apply(ctl("drs_w1", 1'b1, 1'b0, 1'b0, DvW));
        @(negedge clk);
        resetn = 1'b0;
        check_now("drs_reset", Zero);
        @(negedge clk);
        resetn = 1'b1;
        apply(ctl("drs_run", 1'b0, 1'b0, 1'b0, Nrm));
        apply(ctl("drs_restart", 1'b1, 1'b0, 1'b0, DvS));
        for (int i = 1; i < DivCycles; i++) apply(ctl("drs_wait", 1'b1, 1'b0, 1'b0, DvW));
        apply(ctl("drs_release", 1'b1, 1'b0, 1'b0, DvR));
`endif

        // Reset while in FLUSH returns straight to RUN.
        apply(ctl("rfl_exc", 1'b0, 1'b0, 1'b1, Exc));
        @(negedge clk);
        resetn = 1'b0;
        drive(mk("rfl_busy", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Zero));
        check_now("rfl_reset", Zero);
        @(negedge clk);
        resetn = 1'b1;
        apply(ctl("rfl_run", 1'b0, 1'b0, 1'b0, Nrm));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
